mem_ctrl_master: RTL and testbench

MEM_CTRL_MASTER -- requirements
Module: mem_ctrl_master

---
 rtl/mem_ctrl_pkg.sv | 17 +
 rtl/mem_ctrl_master.sv | 120 ++++++++++++
 tb/tb_mem_ctrl_master.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared widths and FSM state type for the memory-controller master.
package mem_ctrl_pkg;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WSETUP  = 3'd1,
    WSTROBE = 3'd2,
    WHOLD   = 3'd3,
    RSTROBE = 3'd4,
    RTURN   = 3'd5
  } state_e;

endpackage

// File: rtl/mem_ctrl_master.sv
// Memory-controller master: turns single client read/write requests into
// MemWr/MemRd strobe sequences on a shared bidirectional 64-bit data bus.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   req_valid/req_write/req_addr/req_wdata   client request
//   req_ready                   high only while idle (request accepted on valid&ready)
//   rsp_valid/rsp_rdata         one-cycle read-done pulse, captured read data
//   wr_done                     one-cycle write-done pulse
//   MemWr/MemRd/Addr/DataBus    memory-side strobes, address and shared data bus
module mem_ctrl_master
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned STROBE_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              wr_done,
  output logic              MemWr,
  output logic              MemRd,
  output logic [ADDR_W-1:0] Addr,
  inout  wire  [DATA_W-1:0] DataBus
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STROBE_CYC - 1);

  state_e              state_q, state_n;
  logic [CNT_W-1:0]    cnt_q, cnt_n;
  logic [DATA_W-1:0]   wdata_q;
  logic                drv_q;
  logic                accept_c;
  logic                capture_c;
  logic                memwr_n, memrd_n, ready_n, rsp_valid_n, wr_done_n, drv_n;

  assign accept_c  = req_valid & req_ready;
  // Read data is sampled on the edge that closes the final strobe cycle.
  assign capture_c = (state_q == RSTROBE) && (cnt_q == '0);

  // Next-state, strobe counter and next registered-output decode.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept_c) begin
          if (req_write) begin
            state_n = WSETUP;
          end else begin
            state_n = RSTROBE;
            cnt_n   = CNT_LOAD;
          end
        end
      end
      WSETUP: begin
        state_n = WSTROBE;
        cnt_n   = CNT_LOAD;
      end
      WSTROBE: begin
        if (cnt_q == '0) state_n = WHOLD;
        else             cnt_n   = cnt_q - CNT_W'(1);
      end
      WHOLD:   state_n = IDLE;
      RSTROBE: begin
        if (cnt_q == '0) state_n = RTURN;
        else             cnt_n   = cnt_q - CNT_W'(1);
      end
      RTURN:   state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // Outputs are registered from the state being entered.
    memwr_n     = (state_n == WSTROBE);
    memrd_n     = (state_n == RSTROBE);
    ready_n     = (state_n == IDLE);
    rsp_valid_n = (state_n == RTURN);
    wr_done_n   = (state_n == WHOLD);
    drv_n       = (state_n == WSETUP) || (state_n == WSTROBE) || (state_n == WHOLD);
  end

  // State, counter, output and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      wr_done   <= 1'b0;
      MemWr     <= 1'b0;
      MemRd     <= 1'b0;
      drv_q     <= 1'b0;
      Addr      <= '0;
      wdata_q   <= '0;
      rsp_rdata <= '0;
    end else begin
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      req_ready <= ready_n;
      rsp_valid <= rsp_valid_n;
      wr_done   <= wr_done_n;
      MemWr     <= memwr_n;
      MemRd     <= memrd_n;
      drv_q     <= drv_n;
      if (accept_c) begin
        Addr <= req_addr;
        if (req_write) wdata_q <= req_wdata;
      end
      if (capture_c) rsp_rdata <= DataBus;
    end
  end

  // Bus is driven only across the write window, released otherwise.
  assign DataBus = drv_q ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_mem_ctrl_master.sv
// Bench for mem_ctrl_master: three builds (STROBE_CYC = 2, 1, 15) share one
// request stream; each has its own memory device on its own bus and is
// checked every cycle against a transaction-level model.
module tb_mem_ctrl_master;

  localparam int NI   = 3;
  localparam int NCYC = 3000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b1;
  logic req_valid = 1'b0;
  logic req_write = 1'b0;
  logic [5:0]  req_addr  = '0;
  logic [63:0] req_wdata = '0;

  wire  [63:0] bus0, bus1, bus2;
  logic [NI-1:0]        rdy, rv, wd, mw, mr;
  logic [NI-1:0][5:0]   ad;
  logic [NI-1:0][63:0]  rdv, busv;

  logic [63:0] dmem [NI][64];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_ctrl_master #(.STROBE_CYC(2)) u_s2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(rdy[0]),
    .rsp_valid(rv[0]), .rsp_rdata(rdv[0]), .wr_done(wd[0]),
    .MemWr(mw[0]), .MemRd(mr[0]), .Addr(ad[0]), .DataBus(bus0));

  mem_ctrl_master #(.STROBE_CYC(1)) u_s1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(rdy[1]),
    .rsp_valid(rv[1]), .rsp_rdata(rdv[1]), .wr_done(wd[1]),
    .MemWr(mw[1]), .MemRd(mr[1]), .Addr(ad[1]), .DataBus(bus1));

  mem_ctrl_master #(.STROBE_CYC(15)) u_s15 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(rdy[2]),
    .rsp_valid(rv[2]), .rsp_rdata(rdv[2]), .wr_done(wd[2]),
    .MemWr(mw[2]), .MemRd(mr[2]), .Addr(ad[2]), .DataBus(bus2));

  // Memory devices: drive the bus while MemRd, store the bus while MemWr.
  assign bus0 = mr[0] ? dmem[0][ad[0]] : 64'bz;
  assign bus1 = mr[1] ? dmem[1][ad[1]] : 64'bz;
  assign bus2 = mr[2] ? dmem[2][ad[2]] : 64'bz;
  assign busv[0] = bus0;
  assign busv[1] = bus1;
  assign busv[2] = bus2;

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (clr) begin
        for (int j = 0; j < 64; j++) dmem[i][j] <= '0;
      end else if (mw[i]) begin
        dmem[i][ad[i]] <= busv[i];
      end
    end
  end

  function automatic int unsigned strobe_of(input int i);
    case (i)
      0:       strobe_of = 2;
      1:       strobe_of = 1;
      default: strobe_of = 15;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Transaction-level model: per build, an in-flight transaction with a
  // cycle index t (1 = first cycle after acceptance).
  bit           m_busy [NI];
  bit           m_wr   [NI];
  bit           m_rdy  [NI];
  int unsigned  m_t    [NI];
  logic [5:0]   m_addr [NI];
  logic [63:0]  m_data [NI];
  logic [63:0]  m_last [NI];
  logic [63:0]  ref_mem [NI][64];

  localparam logic [63:0] D1 = 64'hDEADBEEF_CAFEF00D;
  localparam logic [63:0] D2 = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    for (int i = 0; i < NI; i++) begin
      m_busy[i] = 0; m_wr[i] = 0; m_rdy[i] = 0; m_t[i] = 0;
      m_addr[i] = '0; m_data[i] = '0; m_last[i] = '0;
      for (int j = 0; j < 64; j++) ref_mem[i][j] = '0;
    end

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);

      // Per-cycle comparison against the model.
      for (int i = 0; i < NI; i++) begin
        int unsigned s;
        bit e_mw, e_mr, e_wd, e_rv;
        s    = strobe_of(i);
        e_mw = m_busy[i] && m_wr[i]  && m_t[i] >= 2 && m_t[i] <= s + 1;
        e_mr = m_busy[i] && !m_wr[i] && m_t[i] <= s;
        e_wd = m_busy[i] && m_wr[i]  && m_t[i] == s + 2;
        e_rv = m_busy[i] && !m_wr[i] && m_t[i] == s + 1;
        chk($sformatf("c%0d_i%0d_ready", cyc, i), 64'(rdy[i]), 64'(m_rdy[i]));
        chk($sformatf("c%0d_i%0d_memwr", cyc, i), 64'(mw[i]), 64'(e_mw));
        chk($sformatf("c%0d_i%0d_memrd", cyc, i), 64'(mr[i]), 64'(e_mr));
        chk($sformatf("c%0d_i%0d_wr_done", cyc, i), 64'(wd[i]), 64'(e_wd));
        chk($sformatf("c%0d_i%0d_rsp_valid", cyc, i), 64'(rv[i]), 64'(e_rv));
        chk($sformatf("c%0d_i%0d_addr", cyc, i), 64'(ad[i]), 64'(m_addr[i]));
        chk($sformatf("c%0d_i%0d_rdata", cyc, i), rdv[i], m_last[i]);
        chk($sformatf("c%0d_i%0d_overlap", cyc, i), 64'(mw[i] & mr[i]), 64'd0);
        if (m_busy[i] && m_wr[i])
          chk($sformatf("c%0d_i%0d_bus", cyc, i), busv[i], m_data[i]);
      end

      // Hand-computed expectations pinning the model.
      case (cyc)
        1: begin
          chk("lit_reset_ready", 64'(rdy[0]), 64'd0);
          chk("lit_reset_addr", 64'(ad[0]), 64'd0);
          chk("lit_reset_rdata", rdv[0], 64'd0);
        end
        2:  chk("lit_ready_after_rst", 64'(rdy[0]), 64'd1);
        3: begin
          chk("lit_wsetup_memwr", 64'(mw[0]), 64'd0);
          chk("lit_wsetup_bus", busv[0], D1);
        end
        4:  chk("lit_wstrobe1", 64'(mw[0]), 64'd1);
        5: begin
          chk("lit_wstrobe2", 64'(mw[0]), 64'd1);
          chk("lit_s1_wr_done", 64'(wd[1]), 64'd1);
        end
        6: begin
          chk("lit_wr_done_lat4", 64'(wd[0]), 64'd1);
          chk("lit_whold_memwr", 64'(mw[0]), 64'd0);
          chk("lit_whold_bus", busv[0], D1);
        end
        7:  chk("lit_first_idle_ready", 64'(rdy[0]), 64'd1);
        8: begin
          chk("lit_rstrobe1", 64'(mr[0]), 64'd1);
          chk("lit_s1_rsp_valid", 64'(rv[1]), 64'd1);
        end
        9:  chk("lit_rstrobe2", 64'(mr[0]), 64'd1);
        10: begin
          chk("lit_rsp_valid_lat3", 64'(rv[0]), 64'd1);
          chk("lit_rdata_5", rdv[0], D1);
        end
        19: chk("lit_s15_wr_done", 64'(wd[2]), 64'd1);
        33: begin
          chk("lit_rsp_valid_3f", 64'(rv[0]), 64'd1);
          chk("lit_rdata_3f", rdv[0], D2);
        end
        59: chk("lit_s15_rdata_3f", rdv[2], D2);
        73: chk("lit_rst_wstrobe2", 64'(mw[0]), 64'd1);
        74: begin
          chk("lit_abort_memwr", 64'(mw[0]), 64'd0);
          chk("lit_abort_wr_done", 64'(wd[0]), 64'd0);
          chk("lit_abort_ready", 64'(rdy[0]), 64'd0);
          chk("lit_abort_rdata", rdv[0], 64'd0);
        end
        75: chk("lit_ready_after_abort", 64'(rdy[0]), 64'd1);
        default: ;
      endcase

      // Stimulus for the next edge: directed prologue, then random.
      rst = 1'b0;
      clr = 1'b0;
      req_valid = 1'b0;
      if (cyc == 0) begin
        rst = 1'b1;
      end else if (cyc == 2) begin
        req_valid = 1'b1; req_write = 1'b1; req_addr = 6'h05; req_wdata = D1;
      end else if (cyc >= 3 && cyc <= 7) begin
        req_valid = 1'b1; req_write = 1'b0; req_addr = 6'h05;
      end else if (cyc == 25) begin
        req_valid = 1'b1; req_write = 1'b1; req_addr = 6'h3F; req_wdata = D2;
      end else if (cyc >= 26 && cyc <= 43) begin
        req_valid = 1'b1; req_write = 1'b0; req_addr = 6'h3F;
      end else if (cyc == 70) begin
        req_valid = 1'b1; req_write = 1'b1; req_addr = 6'h11;
        req_wdata = 64'h0123_4567_89AB_CDEF;
      end else if (cyc == 73) begin
        rst = 1'b1;
      end else if (cyc >= 80) begin
        req_valid = ($urandom % 3) != 0;
        req_write = 1'($urandom % 2);
        req_addr  = (($urandom % 4) == 0) ? 6'h3F : 6'($urandom % 8);
        req_wdata = {$urandom, $urandom};
        rst       = ($urandom % 97) == 0;
      end

      // Advance the model across the coming edge.
      for (int i = 0; i < NI; i++) begin
        int unsigned s, last;
        s    = strobe_of(i);
        last = m_wr[i] ? s + 2 : s + 1;
        // The device stores the write data during the first strobe cycle.
        if (m_busy[i] && m_wr[i] && m_t[i] == 2) ref_mem[i][m_addr[i]] = m_data[i];
        if (rst) begin
          m_busy[i] = 0; m_rdy[i] = 0; m_addr[i] = '0; m_last[i] = '0;
        end else if (m_busy[i]) begin
          if (!m_wr[i] && m_t[i] == s) m_last[i] = ref_mem[i][m_addr[i]];
          if (m_t[i] == last) begin
            m_busy[i] = 0; m_rdy[i] = 1;
          end else begin
            m_t[i]++;
          end
        end else if (m_rdy[i] && req_valid) begin
          m_busy[i] = 1; m_wr[i] = req_write; m_t[i] = 1;
          m_addr[i] = req_addr; m_data[i] = req_wdata; m_rdy[i] = 0;
        end else begin
          m_rdy[i] = 1;
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
